// File: rtl/servo_pkg.sv
// servo_pkg: shared width type, default timing parameters, FSM encoding and width clamp helper
package servo_pkg;
  localparam int WW = 19;
  typedef logic [WW-1:0] width_t;
  localparam int DEF_FRAME_CYC = 1000000;
  localparam int DEF_MIN_W = 18000;
  localparam int DEF_MAX_W = 130000;
  localparam int DEF_INIT_W = 74250;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
  function automatic width_t clamp_w(input width_t w, input width_t lo, input width_t hi);
    return w < lo ? lo : w > hi ? hi : w;
  endfunction
endpackage

// File: rtl/servo_rr_arb.sv
// servo_rr_arb: two-channel sweep arbiter, evaluates on frame_start, holds grant until sdone or sreq drop
module servo_rr_arb
  import servo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [1:0] sreq,
  input  logic [1:0] sdone,
  output logic [1:0] sgnt
);
  logic       prio;
  logic [1:0] pick;
  assign pick = &sreq ? (prio ? 2'b10 : 2'b01) : sreq;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sgnt <= '0;
      prio <= 1'b0;
    end else if (|sgnt) begin
      if (|(sgnt & (sdone | ~sreq))) sgnt <= '0;
    end else if (frame_start && |pick) begin
      sgnt <= pick;
      prio <= pick[0];
    end
endmodule

// File: rtl/servo_pwm_sched.sv
// servo_pwm_sched: two-channel servo PWM frame generator with clamped shadow widths and frame-gated sweep arbiter
module servo_pwm_sched
  import servo_pkg::*;
#(
  parameter int FRAME_CYC = DEF_FRAME_CYC,
  parameter int MIN_W     = DEF_MIN_W,
  parameter int MAX_W     = DEF_MAX_W,
  parameter int INIT_W    = DEF_INIT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [WW-1:0] w0,
  input  logic [WW-1:0] w1,
  input  logic          wv0,
  input  logic          wv1,
  input  logic          sreq0,
  input  logic          sreq1,
  input  logic          sdone0,
  input  logic          sdone1,
  output logic          pwm0,
  output logic          pwm1,
  output logic          frame_start,
  output logic [WW-1:0] wa0,
  output logic [WW-1:0] wa1,
  output logic          sgnt0,
  output logic          sgnt1,
  output logic          clamp
);
  localparam int CW = $clog2(FRAME_CYC);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYC - 1);
  localparam width_t LO = width_t'(MIN_W);
  localparam width_t HI = width_t'(MAX_W);
  localparam width_t INI = width_t'(INIT_W);
  state_t        state, nxt_state;
  logic [CW-1:0] fcnt, nxt_fcnt;
  width_t        sh0, sh1, nxt_wa0, nxt_wa1;
  logic          run, last, load, oor0, oor1;
  logic [1:0]    sgnt;
  assign run = state != IDLE;
  assign last = run && fcnt == LAST;
  assign load = (state == IDLE && en) || last;
  assign oor0 = wv0 && (w0 < LO || w0 > HI);
  assign oor1 = wv1 && (w1 < LO || w1 > HI);
  always_comb begin
    nxt_state = (!run || last) ? (en ? RUN : IDLE) : (en ? state : STOP);
    nxt_fcnt = (!run || last) ? '0 : fcnt + CW'(1);
    nxt_wa0 = load ? sh0 : wa0;
    nxt_wa1 = load ? sh1 : wa1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fcnt <= '0;
      sh0 <= INI;
      sh1 <= INI;
      wa0 <= INI;
      wa1 <= INI;
      pwm0 <= 1'b0;
      pwm1 <= 1'b0;
      frame_start <= 1'b0;
      clamp <= 1'b0;
    end else begin
      state <= nxt_state;
      fcnt <= nxt_fcnt;
      wa0 <= nxt_wa0;
      wa1 <= nxt_wa1;
      pwm0 <= nxt_state != IDLE && 32'(nxt_fcnt) < 32'(nxt_wa0);
      pwm1 <= nxt_state != IDLE && 32'(nxt_fcnt) < 32'(nxt_wa1);
      frame_start <= nxt_state == RUN && load;
      clamp <= oor0 | oor1;
      if (wv0) sh0 <= clamp_w(w0, LO, HI);
      if (wv1) sh1 <= clamp_w(w1, LO, HI);
    end
  servo_rr_arb u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .sreq       ({sreq1, sreq0}),
    .sdone      ({sdone1, sdone0}),
    .sgnt       (sgnt)
  );
  assign sgnt0 = sgnt[0];
  assign sgnt1 = sgnt[1];
endmodule
